// File: rtl/oled_pkg.sv
// Shared constants, state encoding and small helpers for the OLED glyph writer.
package oled_pkg;

    localparam logic [7:0] CMD_PAGE_BASE   = 8'hB0;
    localparam logic [7:0] CMD_COL_LO_BASE = 8'h00;
    localparam logic [7:0] CMD_COL_HI_BASE = 8'h10;
    localparam int         GLYPH_W         = 8;
    localparam int         NUM_PAGES       = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_PAGE,
        ST_CMD_COL_LO,
        ST_CMD_COL_HI,
        ST_ROM_RD,
        ST_DATA,
        ST_DONE
    } state_t;

    // Number of glyph columns that still land on the panel when drawn from column x.
    function automatic logic [3:0] glyph_span(input logic [6:0] x, input int num_cols);
        int room;
        room = num_cols - int'(x);
        if (room <= 0)
            return 4'd0;
        if (room >= GLYPH_W)
            return 4'(GLYPH_W);
        return 4'(room);
    endfunction

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= 8'h20) && (code <= 8'h7E);
    endfunction

endpackage

// File: rtl/oled_font_rom_8x8.sv
// 8x8 column-major font ROM: address {code[6:0], col[2:0]}, bit0 = top pixel row.
module oled_font_rom_8x8 (
    input  logic       clk_50m,
    input  logic [9:0] addr,
    output logic [7:0] rdata
);
    import oled_pkg::*;

    // Each glyph is 8 columns, column 0 in the most significant byte.
    function automatic logic [7:0] font_col(input logic [9:0] a);
        logic [6:0]  code;
        logic [63:0] g;
        int          c;
        code = a[9:3];
        // Lowercase reuses the uppercase shapes to keep the table compact.
        if (code >= 7'h61 && code <= 7'h7A)
            code = code - 7'h20;
        case (code)
            7'h21: g = 64'h00_00_00_5F_00_00_00_00;
            7'h22: g = 64'h00_00_07_00_07_00_00_00;
            7'h23: g = 64'h00_14_7F_14_7F_14_00_00;
            7'h24: g = 64'h00_24_2A_7F_2A_12_00_00;
            7'h25: g = 64'h00_23_13_08_64_62_00_00;
            7'h26: g = 64'h00_36_49_55_22_50_00_00;
            7'h27: g = 64'h00_00_05_03_00_00_00_00;
            7'h28: g = 64'h00_00_1C_22_41_00_00_00;
            7'h29: g = 64'h00_00_41_22_1C_00_00_00;
            7'h2A: g = 64'h00_14_08_3E_08_14_00_00;
            7'h2B: g = 64'h00_08_08_3E_08_08_00_00;
            7'h2C: g = 64'h00_00_50_30_00_00_00_00;
            7'h2D: g = 64'h00_08_08_08_08_08_00_00;
            7'h2E: g = 64'h00_00_60_60_00_00_00_00;
            7'h2F: g = 64'h00_20_10_08_04_02_00_00;
            7'h30: g = 64'h00_3E_51_49_45_3E_00_00;
            7'h31: g = 64'h00_00_42_7F_40_00_00_00;
            7'h32: g = 64'h00_42_61_51_49_46_00_00;
            7'h33: g = 64'h00_21_41_45_4B_31_00_00;
            7'h34: g = 64'h00_18_14_12_7F_10_00_00;
            7'h35: g = 64'h00_27_45_45_45_39_00_00;
            7'h36: g = 64'h00_3C_4A_49_49_30_00_00;
            7'h37: g = 64'h00_01_71_09_05_03_00_00;
            7'h38: g = 64'h00_36_49_49_49_36_00_00;
            7'h39: g = 64'h00_06_49_49_29_1E_00_00;
            7'h3A: g = 64'h00_00_36_36_00_00_00_00;
            7'h3B: g = 64'h00_00_56_36_00_00_00_00;
            7'h3C: g = 64'h00_08_14_22_41_00_00_00;
            7'h3D: g = 64'h00_14_14_14_14_14_00_00;
            7'h3E: g = 64'h00_00_41_22_14_08_00_00;
            7'h3F: g = 64'h00_02_01_51_09_06_00_00;
            7'h40: g = 64'h00_32_49_79_41_3E_00_00;
            7'h41: g = 64'h00_7C_12_11_12_7C_00_00;
            7'h42: g = 64'h00_7F_49_49_49_36_00_00;
            7'h43: g = 64'h00_3E_41_41_41_22_00_00;
            7'h44: g = 64'h00_7F_41_41_22_1C_00_00;
            7'h45: g = 64'h00_7F_49_49_49_41_00_00;
            7'h46: g = 64'h00_7F_09_09_09_01_00_00;
            7'h47: g = 64'h00_3E_41_49_49_7A_00_00;
            7'h48: g = 64'h00_7F_08_08_08_7F_00_00;
            7'h49: g = 64'h00_00_41_7F_41_00_00_00;
            7'h4A: g = 64'h00_20_40_41_3F_01_00_00;
            7'h4B: g = 64'h00_7F_08_14_22_41_00_00;
            7'h4C: g = 64'h00_7F_40_40_40_40_00_00;
            7'h4D: g = 64'h00_7F_02_1C_02_7F_00_00;
            7'h4E: g = 64'h00_7F_04_08_10_7F_00_00;
            7'h4F: g = 64'h00_3E_41_41_41_3E_00_00;
            7'h50: g = 64'h00_7F_09_09_09_06_00_00;
            7'h51: g = 64'h00_3E_41_51_21_5E_00_00;
            7'h52: g = 64'h00_7F_09_19_29_46_00_00;
            7'h53: g = 64'h00_46_49_49_49_31_00_00;
            7'h54: g = 64'h00_01_01_7F_01_01_00_00;
            7'h55: g = 64'h00_3F_40_40_40_3F_00_00;
            7'h56: g = 64'h00_1F_20_40_20_1F_00_00;
            7'h57: g = 64'h00_3F_40_38_40_3F_00_00;
            7'h58: g = 64'h00_63_14_08_14_63_00_00;
            7'h59: g = 64'h00_07_08_70_08_07_00_00;
            7'h5A: g = 64'h00_61_51_49_45_43_00_00;
            7'h5B: g = 64'h00_00_7F_41_41_00_00_00;
            7'h5C: g = 64'h00_02_04_08_10_20_00_00;
            7'h5D: g = 64'h00_00_41_41_7F_00_00_00;
            7'h5E: g = 64'h00_04_02_01_02_04_00_00;
            7'h5F: g = 64'h00_40_40_40_40_40_00_00;
            7'h60: g = 64'h00_00_01_02_04_00_00_00;
            7'h7B: g = 64'h00_00_08_36_41_00_00_00;
            7'h7C: g = 64'h00_00_00_7F_00_00_00_00;
            7'h7D: g = 64'h00_00_41_36_08_00_00_00;
            7'h7E: g = 64'h00_08_04_08_10_08_00_00;
            default: g = 64'h0;
        endcase
        c = int'(a[2:0]);
        return g[8*(7-c) +: 8];
    endfunction

    always_ff @(posedge clk_50m) begin
        rdata <= font_col(addr);
    end

endmodule

// File: rtl/oled_glyph_writer.sv
// Streams one 8x8 glyph to an SSD1306-style OLED: page/column commands, then column bytes.
module oled_glyph_writer #(
    parameter int NUM_COLS = 128
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] ascii,
    input  logic [6:0] x,
    input  logic [3:0] y,
    output logic       char_busy,
    output logic       char_done,
    output logic       wr_valid,
    output logic [7:0] wr_byte,
    output logic       wr_dc,
    input  logic       wr_ready
);
    import oled_pkg::*;

    state_t     state;
    logic [7:0] ascii_q;
    logic [6:0] x_q;
    logic [3:0] y_q;
    logic [3:0] col_q;
    logic [3:0] ncols_q;
    logic [7:0] rom_q;
    logic [9:0] rom_addr;

    // col_q is bumped on entering DATA, so the ROM is already fetching the next
    // column while the current byte waits for its handshake.
    assign rom_addr = {ascii_q[6:0], col_q[2:0]};

    oled_font_rom_8x8 u_font (
        .clk_50m (clk_50m),
        .addr    (rom_addr),
        .rdata   (rom_q)
    );

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            char_busy <= 1'b0;
            char_done <= 1'b0;
            wr_valid  <= 1'b0;
            wr_byte   <= 8'h00;
            wr_dc     <= 1'b0;
            ascii_q   <= 8'h00;
            x_q       <= 7'h00;
            y_q       <= 4'h0;
            col_q     <= 4'h0;
            ncols_q   <= 4'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    char_done <= 1'b0;
                    if (start) begin
                        ascii_q   <= ascii;
                        x_q       <= x;
                        y_q       <= y;
                        col_q     <= 4'h0;
                        ncols_q   <= glyph_span(x, NUM_COLS);
                        char_busy <= 1'b1;
                        wr_valid  <= (int'(y) < NUM_PAGES);
                        wr_byte   <= CMD_PAGE_BASE | {5'd0, y[2:0]};
                        wr_dc     <= 1'b0;
                        state     <= ST_CMD_PAGE;
                    end
                end
                ST_CMD_PAGE: begin
                    if (int'(y_q) >= NUM_PAGES) begin
                        char_busy <= 1'b0;
                        char_done <= 1'b1;
                        state     <= ST_DONE;
                    end else if (wr_ready) begin
                        wr_byte <= CMD_COL_LO_BASE | {4'd0, x_q[3:0]};
                        state   <= ST_CMD_COL_LO;
                    end
                end
                ST_CMD_COL_LO: begin
                    if (wr_ready) begin
                        wr_byte <= CMD_COL_HI_BASE | {5'd0, x_q[6:4]};
                        state   <= ST_CMD_COL_HI;
                    end
                end
                ST_CMD_COL_HI: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        if (ncols_q == 4'd0) begin
                            char_busy <= 1'b0;
                            char_done <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_ROM_RD;
                        end
                    end
                end
                ST_ROM_RD: begin
                    wr_valid <= 1'b1;
                    wr_dc    <= 1'b1;
                    wr_byte  <= is_printable(ascii_q) ? rom_q : 8'h00;
                    col_q    <= col_q + 4'd1;
                    state    <= ST_DATA;
                end
                ST_DATA: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        if (col_q == ncols_q) begin
                            char_busy <= 1'b0;
                            char_done <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_ROM_RD;
                        end
                    end
                end
                ST_DONE: begin
                    char_done <= 1'b0;
                    wr_dc     <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_glyph_writer.sv
// Directed bench for oled_glyph_writer: vector table plus stall/busy-start/reset sequences.
module tb_oled_glyph_writer;

    logic       clk_50m = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] ascii;
    logic [6:0] x;
    logic [3:0] y;
    logic       char_busy, char_done, wr_valid, wr_dc, wr_ready;
    logic [7:0] wr_byte;

    oled_glyph_writer dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .start     (start),
        .ascii     (ascii),
        .x         (x),
        .y         (y),
        .char_busy (char_busy),
        .char_done (char_done),
        .wr_valid  (wr_valid),
        .wr_byte   (wr_byte),
        .wr_dc     (wr_dc),
        .wr_ready  (wr_ready)
    );

    always #10 clk_50m = ~clk_50m;

    typedef struct {
        logic [7:0]       a;
        logic [6:0]       xx;
        logic [3:0]       yy;
        int               n;
        logic [10:0][8:0] b;
        int               cyc;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] cap[$];
    int         done_cnt, done_cyc, busy_cyc;
    vec_t       vec[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // cmds: three command bytes MSB first; data: column 0 in the top byte.
    function automatic vec_t mkvec(input logic [7:0] a, input logic [6:0] xx, input logic [3:0] yy,
                                   input int n, input int cyc, input logic [23:0] cmds,
                                   input logic [63:0] data);
        vec_t v;
        v.a = a; v.xx = xx; v.yy = yy; v.n = n; v.cyc = cyc;
        for (int i = 0; i < 11; i++) begin
            if (i < 3) v.b[i] = {1'b0, cmds[8*(2-i) +: 8]};
            else       v.b[i] = {1'b1, data[8*(10-i) +: 8]};
        end
        return v;
    endfunction

    task automatic run_glyph(input logic [7:0] a, input logic [6:0] xx, input logic [3:0] yy,
                             input int stall_idx, input int stall_len, input int dup_k,
                             input int rst_idx);
        int         ndata, stall_rem, rst_k;
        logic       pv, pr;
        logic [8:0] pb;
        cap.delete();
        done_cnt = 0; done_cyc = 0; busy_cyc = 0;
        ndata = 0; stall_rem = stall_len; rst_k = 0; pv = 0; pr = 1; pb = '0;
        @(negedge clk_50m);
        ascii = a; x = xx; y = yy; start = 1'b1; wr_ready = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk_50m);
            if (k == 1) begin
                start = 1'b0; ascii = 8'h5A; x = 7'h55; y = 4'h3;
            end
            if (dup_k > 0 && k == dup_k) begin
                start = 1'b1; ascii = 8'h41; x = 7'h10; y = 4'h1;
            end else if (dup_k > 0 && k == dup_k + 1) begin
                start = 1'b0;
            end
            if (rst_k > 0 && k == rst_k + 1) rst = 1'b0;
            if (pv && !pr) check("stall_hold", {wr_valid, wr_dc, wr_byte}, {1'b1, pb});
            wr_ready = 1'b1;
            if (wr_valid && wr_dc && ndata == stall_idx && stall_rem > 0) begin
                wr_ready = 1'b0;
                stall_rem--;
            end
            if (wr_valid && wr_dc && ndata == rst_idx && rst_k == 0) begin
                rst = 1'b1;
                #1;
                check("rst_abort", {char_busy, char_done, wr_valid, wr_dc, wr_byte}, 32'h0);
                rst_k = k;
            end
            if (char_busy) busy_cyc++;
            if (char_done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (wr_valid && wr_ready) begin
                cap.push_back({wr_dc, wr_byte});
                if (wr_dc) ndata++;
            end
            pv = wr_valid; pr = wr_ready; pb = {wr_dc, wr_byte};
            if (done_cyc > 0 && k >= done_cyc + 3) break;
            if (rst_k > 0 && k >= rst_k + 4) break;
        end
        if (done_cyc == 0 && rst_k == 0)
            $display("FAIL timeout: glyph %0h never signalled char_done", a);
        wr_ready = 1'b1; start = 1'b0; rst = 1'b0;
    endtask

    task automatic check_bytes(input string tag, input vec_t v);
        logic [8:0] got;
        check({tag, "_nbytes"}, cap.size(), v.n);
        for (int i = 0; i < v.n; i++) begin
            got = (i < cap.size()) ? cap[i] : 9'h1FF;
            check($sformatf("%s_byte%0d", tag, i), got, v.b[i]);
        end
    endtask

    task automatic check_run(input string tag, input vec_t v, input int exp_cyc, input int exp_done);
        check_bytes(tag, v);
        check({tag, "_done_cnt"}, done_cnt, exp_done);
        check({tag, "_cycles"}, done_cyc, exp_cyc);
        check({tag, "_busy_cycles"}, busy_cyc, exp_cyc - 1);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; start = 1'b0; ascii = 8'h00; x = 7'h00; y = 4'h0; wr_ready = 1'b1;
        vec[0] = mkvec(8'h41, 7'd16,  4'd2, 11, 20, 24'hB2_00_11, 64'h00_7C_12_11_12_7C_00_00);
        vec[1] = mkvec(8'h30, 7'd124, 4'd0,  7, 12, 24'hB0_0C_17, 64'h00_3E_51_49_00_00_00_00);
        vec[2] = mkvec(8'h41, 7'd5,   4'd9,  0,  2, 24'h0,        64'h0);
        vec[3] = mkvec(8'h42, 7'd127, 4'd5,  4,  6, 24'hB5_0F_17, 64'h0);
        vec[4] = mkvec(8'h07, 7'd0,   4'd0, 11, 20, 24'hB0_00_10, 64'h0);
        vec[5] = mkvec(8'h7F, 7'd40,  4'd7, 11, 20, 24'hB7_08_12, 64'h0);
        vec[6] = mkvec(8'h5A, 7'd120, 4'd3, 11, 20, 24'hB3_08_17, 64'h00_61_51_49_45_43_00_00);

        repeat (3) @(negedge clk_50m);
        check("reset_outputs", {char_busy, char_done, wr_valid, wr_dc, wr_byte}, 32'h0);
        rst = 1'b0;
        @(negedge clk_50m);

        foreach (vec[i]) begin
            run_glyph(vec[i].a, vec[i].xx, vec[i].yy, -1, 0, 0, -1);
            check_run($sformatf("vec%0d", i), vec[i], vec[i].cyc, 1);
        end

        // Ready dropped for 5 cycles on the 3rd data byte.
        run_glyph(8'h41, 7'd16, 4'd2, 2, 5, 0, -1);
        check_run("stall", vec[0], 25, 1);

        // Second start while busy must not disturb the glyph.
        run_glyph(8'h07, 7'd0, 4'd0, -1, 0, 5, -1);
        check_run("busy_start", vec[4], 20, 1);

        // Start landing in the DONE cycle is dropped.
        run_glyph(8'h41, 7'd16, 4'd2, -1, 0, 20, -1);
        check_run("done_start", vec[0], 20, 1);

        // Reset during the 5th data byte, then a clean glyph.
        run_glyph(8'h41, 7'd16, 4'd2, -1, 0, 0, 4);
        check("rst_no_done", done_cnt, 0);
        check("rst_partial_bytes", cap.size(), 7);
        v = mkvec(8'h42, 7'd0, 4'd7, 11, 20, 24'hB7_00_10, 64'h00_7F_49_49_49_36_00_00);
        run_glyph(v.a, v.xx, v.yy, -1, 0, 0, -1);
        check_run("after_rst", v, 20, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
